// File: rtl/sevenseg_scan_driver.sv
`timescale 1ns/1ps
// sevenseg_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Display values are captured into shadow registers on Load and scanned one
// digit per refresh slot. Each slot starts with GUARD dark cycles so the
// previous digit's segments never ghost onto the next anode. Supports
// per-digit enable, decimal point, blink and leading-zero blanking.
// Every output is registered. LIT values are frozen for the rest of the slot.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Load,
  input  logic [4*NUM_DIGITS-1:0]       HexVals,
  input  logic [NUM_DIGITS-1:0]         DigitEn,
  input  logic [NUM_DIGITS-1:0]         DpIn,
  input  logic [NUM_DIGITS-1:0]         BlinkEn,
  input  logic                          BlankLeadZeros,
  output logic [0:6]                    Seg,
  output logic                          Dp,
  output logic [NUM_DIGITS-1:0]         An,
  output logic [$clog2(NUM_DIGITS)-1:0] DigitIdx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [REF_W-1:0] LIT_ENTRY = REF_W'(GUARD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [0:6]       SEG_OFF   = 7'b1111111;

  // Active-low a..g pattern for one hex nibble; index 0 of the result is segment a.
  function automatic logic [0:6] hex_to_seg(input logic [3:0] nib);
    logic [0:6] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Shadow copies of the display inputs
  logic [4*NUM_DIGITS-1:0] sh_hex;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_blz;

  // Scan state
  logic [REF_W-1:0] ref_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;

  // Slot/frame strobes
  logic at_wrap;
  logic at_lit_entry;
  logic frame_done;

  // Values as they will stand after this edge (Load bypasses the shadows)
  logic [4*NUM_DIGITS-1:0] eff_hex;
  logic [NUM_DIGITS-1:0]   eff_en;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_blink;
  logic                    eff_blz;

  // Leading-zero analysis and current-digit selection
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lead_blank;
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_blank;

  // Next LIT output values for the current digit
  logic [NUM_DIGITS-1:0] lit_an;
  logic [0:6]            lit_seg;
  logic                  lit_dp;

  assign at_wrap      = (ref_cnt == REF_LAST);
  assign at_lit_entry = (ref_cnt == LIT_ENTRY);
  assign frame_done   = at_wrap && (DigitIdx == IDX_LAST);

  // Capture the display inputs whenever Load is high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sh_hex   <= '0;
      sh_en    <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_blz   <= 1'b0;
    end else if (Load) begin
      sh_hex   <= HexVals;
      sh_en    <= DigitEn;
      sh_dp    <= DpIn;
      sh_blink <= BlinkEn;
      sh_blz   <= BlankLeadZeros;
    end
  end

  // Refresh counter: one slot per REFRESH_DIV cycles.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ref_cnt <= '0;
    end else if (at_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Digit index advances at each slot wrap, returning to 0 after the last digit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      DigitIdx <= '0;
    end else if (at_wrap) begin
      if (DigitIdx == IDX_LAST) begin
        DigitIdx <= '0;
      end else begin
        DigitIdx <= DigitIdx + 1'b1;
      end
    end
  end

  // Count completed frames; flip the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_done) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // A Load on the LIT-entry edge must show in this slot, so bypass the shadows.
  always_comb begin
    eff_hex   = Load ? HexVals        : sh_hex;
    eff_en    = Load ? DigitEn        : sh_en;
    eff_dp    = Load ? DpIn           : sh_dp;
    eff_blink = Load ? BlinkEn        : sh_blink;
    eff_blz   = Load ? BlankLeadZeros : sh_blz;
  end

  // Walk from the most significant digit down; a digit is a leading zero while
  // it and every digit above it are zero. Digit 0 always shows.
  always_comb begin
    zero_run   = 1'b1;
    lead_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (eff_hex[4*i +: 4] == 4'h0);
      lead_blank[i] = eff_blz && zero_run && (i > 0);
    end
  end

  // Pick out the attributes of the digit being scanned.
  always_comb begin
    cur_nib   = '0;
    cur_en    = 1'b0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (DigitIdx == IDX_W'(i)) begin
        cur_nib   = eff_hex[4*i +: 4];
        cur_en    = eff_en[i];
        cur_dp    = eff_dp[i];
        cur_blink = eff_blink[i];
        cur_blank = lead_blank[i];
      end
    end
  end

  // Build the LIT outputs; a disabled or blinked-off digit stays dark.
  always_comb begin
    lit_an  = '1;
    lit_seg = SEG_OFF;
    lit_dp  = 1'b1;
    if (cur_en && !(cur_blink && blink_phase)) begin
      lit_an  = ~(NUM_DIGITS'(1) << DigitIdx);
      lit_seg = cur_blank ? SEG_OFF : hex_to_seg(cur_nib);
      lit_dp  = ~cur_dp;
    end
  end

  // Registered pins: dark on the slot wrap, loaded on LIT entry, held otherwise.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      An  <= '1;
      Seg <= SEG_OFF;
      Dp  <= 1'b1;
    end else if (at_wrap) begin
      An  <= '1;
      Seg <= SEG_OFF;
      Dp  <= 1'b1;
    end else if (at_lit_entry) begin
      An  <= lit_an;
      Seg <= lit_seg;
      Dp  <= lit_dp;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
`timescale 1ns/1ps
// Bench for sevenseg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2,
// BLINK_FRAMES=2). Expected per-slot outputs are queued before each slot and
// popped when that slot is observed.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Load;
  logic [15:0] HexVals;
  logic [3:0]  DigitEn;
  logic [3:0]  DpIn;
  logic [3:0]  BlinkEn;
  logic        BlankLeadZeros;
  logic [0:6]  Seg;
  logic        Dp;
  logic [3:0]  An;
  logic [1:0]  DigitIdx;

  sevenseg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLINK_FRAMES(2)
  ) dut (
    .Clock(clk), .Reset(Reset), .Load(Load), .HexVals(HexVals),
    .DigitEn(DigitEn), .DpIn(DpIn), .BlinkEn(BlinkEn),
    .BlankLeadZeros(BlankLeadZeros), .Seg(Seg), .Dp(Dp), .An(An),
    .DigitIdx(DigitIdx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [0:6] seg;
    logic       dp;
    int         idx;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   slot_no = 0;

  logic [15:0] m_hex;
  logic [3:0]  m_en, m_dp, m_blink;
  logic        m_blz;

  logic [0:6] dec_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t model(input int d);
    ent_t e;
    bit   ph;
    bit   z;
    ph    = ((slot_no / 8) % 2) == 1;
    e.an  = 4'hF;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    e.idx = d;
    if (m_en[d] && !(m_blink[d] && ph)) begin
      e.an[d] = 1'b0;
      z = m_blz && (d > 0) && ((m_hex >> (4*d)) == 16'h0);
      e.seg = z ? 7'b1111111 : dec_tab[m_hex[4*d +: 4]];
      e.dp  = ~m_dp[d];
    end
    return e;
  endfunction

  task automatic push_model();
    sb.push_back(model(slot_no % 4));
  endtask

  task automatic push_const(input logic [3:0] an, input logic [0:6] seg, input logic dp);
    ent_t e;
    e.an = an; e.seg = seg; e.dp = dp; e.idx = slot_no % 4;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] hx, input logic [3:0] en, input logic [3:0] dp,
                         input logic [3:0] bl, input logic blz);
    HexVals = hx; DigitEn = en; DpIn = dp; BlinkEn = bl; BlankLeadZeros = blz;
    m_hex = hx; m_en = en; m_dp = dp; m_blink = bl; m_blz = blz;
    Load = 1'b1;
  endtask

  // Entered at a falling edge with RefCnt=0; leaves at the next slot's RefCnt=0.
  task automatic run_slot(input string tag, input bit mid, input logic [15:0] mid_hex);
    ent_t e;
    if (sb.size() == 0) begin
      e.an = 4'hF; e.seg = 7'b1111111; e.dp = 1'b1; e.idx = -1;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, ":idx"}, 32'(DigitIdx), 32'(e.idx));
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        @(negedge clk);
        Load = 1'b0;
      end
      chk({tag, ":guard_an"},  32'(An),  32'hF);
      chk({tag, ":guard_seg"}, 32'(Seg), 32'h7F);
      chk({tag, ":guard_dp"},  32'(Dp),  32'h1);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk({tag, ":an"},     32'(An),  32'(e.an));
      chk({tag, ":seg"},    32'(Seg), 32'(e.seg));
      chk({tag, ":dp"},     32'(Dp),  32'(e.dp));
      chk({tag, ":onehot"}, 32'($countones(~An) <= 1), 32'h1);
      if (mid && j == 2) begin
        HexVals = mid_hex;
        m_hex   = mid_hex;
        Load    = 1'b1;
      end
      if (mid && j == 3) Load = 1'b0;
    end
    @(negedge clk);
    slot_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Load = 1'b0; HexVals = '0; DigitEn = '0; DpIn = '0;
    BlinkEn = '0; BlankLeadZeros = 1'b0;
    m_hex = '0; m_en = '0; m_dp = '0; m_blink = '0; m_blz = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset:an",  32'(An),       32'hF);
    chk("reset:seg", 32'(Seg),      32'h7F);
    chk("reset:dp",  32'(Dp),       32'h1);
    chk("reset:idx", 32'(DigitIdx), 32'h0);
    Reset = 1'b0;
    slot_no = 0;

    // Basic scan of 0x3A1F
    do_load(16'h3A1F, 4'hF, 4'h0, 4'h0, 1'b0);
    push_const(4'b1110, 7'b0111000, 1'b1); run_slot("scan_d0", 0, '0);
    push_const(4'b1101, 7'b1001111, 1'b1); run_slot("scan_d1", 0, '0);
    push_const(4'b1011, 7'b0001000, 1'b1); run_slot("scan_d2", 0, '0);
    push_const(4'b0111, 7'b0000110, 1'b1); run_slot("scan_d3", 0, '0);

    // Load at RefCnt=4 of digit 2 shows from digit 3 onward
    push_model(); run_slot("mid_d0", 0, '0);
    push_model(); run_slot("mid_d1", 0, '0);
    push_const(4'b1011, 7'b0001000, 1'b1); run_slot("mid_d2", 1, 16'h9876);
    push_const(4'b0111, 7'b0000100, 1'b1); run_slot("mid_d3", 0, '0);

    // Sweep every nibble value on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'h3A10 | 16'(v), 4'hF, 4'h0, 4'h0, 1'b0);
      for (int d = 0; d < 4; d++) begin
        push_model();
        run_slot($sformatf("sweep%0d_d%0d", v, d), 0, '0);
      end
    end

    // Leading-zero blanking
    do_load(16'h0050, 4'hF, 4'b1000, 4'h0, 1'b1);
    push_const(4'b1110, 7'b0000001, 1'b1); run_slot("lz50_d0", 0, '0);
    push_const(4'b1101, 7'b0100100, 1'b1); run_slot("lz50_d1", 0, '0);
    push_const(4'b1011, 7'b1111111, 1'b1); run_slot("lz50_d2", 0, '0);
    push_const(4'b0111, 7'b1111111, 1'b0); run_slot("lz50_d3", 0, '0);
    do_load(16'h0000, 4'hF, 4'b1000, 4'h0, 1'b1);
    push_const(4'b1110, 7'b0000001, 1'b1); run_slot("lz00_d0", 0, '0);
    push_const(4'b1101, 7'b1111111, 1'b1); run_slot("lz00_d1", 0, '0);
    push_const(4'b1011, 7'b1111111, 1'b1); run_slot("lz00_d2", 0, '0);
    push_const(4'b0111, 7'b1111111, 1'b0); run_slot("lz00_d3", 0, '0);

    // Reset at RefCnt=5 of digit 1
    push_model(); run_slot("prerst_d0", 0, '0);
    repeat (5) @(negedge clk);
    chk("prerst_d1:an", 32'(An), 32'(4'b1101));
    Reset = 1'b1;
    #1;
    chk("rst_async:an",  32'(An),       32'hF);
    chk("rst_async:seg", 32'(Seg),      32'h7F);
    chk("rst_async:dp",  32'(Dp),       32'h1);
    chk("rst_async:idx", 32'(DigitIdx), 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    m_hex = '0; m_en = '0; m_dp = '0; m_blink = '0; m_blz = 1'b0;
    slot_no = 0;
    for (int d = 0; d < 4; d++) begin
      push_model();
      run_slot($sformatf("rst_clear_d%0d", d), 0, '0);
    end

    // Second reset, then blink on digit 0 over six frames
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    slot_no = 0;
    do_load(16'h7650, 4'hF, 4'h0, 4'b0001, 1'b0);
    push_const(4'b1110, 7'b0000001, 1'b1); run_slot("rst_d0", 0, '0);
    for (int s = 1; s < 24; s++) begin
      if ((s % 4 == 0) && (s / 4 == 2 || s / 4 == 3)) push_const(4'hF, 7'b1111111, 1'b1);
      else push_model();
      run_slot($sformatf("blink_f%0d_d%0d", s / 4, s % 4), 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
